// File: rtl/mem_map_pkg.sv
// Memory-map package for mem_region_ctrl.
// Holds the default map constants, the region, fault-code and FSM state
// enums, the latched request payload, and byte-enable helper functions.
`timescale 1ns/1ps
package mem_map_pkg;

  localparam logic [31:0] DEF_TEXT_BASE   = 32'h0040_0000;
  localparam int unsigned DEF_TEXT_WORDS  = 1024;
  localparam logic [31:0] DEF_STATIC_BASE = 32'h1000_0000;
  localparam logic [31:0] DEF_DYN_BASE    = 32'h1000_8000;
  localparam int unsigned DEF_DATA_WORDS  = 1024;
  localparam int unsigned DEF_WAIT_STATES = 1;

  typedef enum logic [1:0] {REG_NONE, REG_TEXT, REG_STATIC, REG_DYN} region_e;

  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_MISALIGN = 2'b01,
    FC_UNMAPPED = 2'b10,
    FC_TEXT     = 2'b11
  } fault_e;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_e;

  // Request fields kept for the ACCESS phase (address is reduced to a word index)
  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  // Word, matching half-word, or single byte in its own lane
  function automatic logic legal_be(input logic [3:0] be, input logic [1:0] off);
    case (be)
      4'b1111: legal_be = (off == 2'd0);
      4'b0011: legal_be = (off == 2'd0);
      4'b1100: legal_be = (off == 2'd2);
      4'b0001: legal_be = (off == 2'd0);
      4'b0010: legal_be = (off == 2'd1);
      4'b0100: legal_be = (off == 2'd2);
      4'b1000: legal_be = (off == 2'd3);
      default: legal_be = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    for (int i = 0; i < 4; i++) be_mask[8*i +: 8] = {8{be[i]}};
  endfunction

endpackage

// File: rtl/mem_region_ctrl_if.sv
// Load/store port between the core and mem_region_ctrl.
// master: drives req_* and receives req_ready and rsp_*; slave: the controller.
`timescale 1ns/1ps
interface mem_region_ctrl_if;
  import mem_map_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  fault_e      rsp_fault_code;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_fault_code
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_fault_code
  );
endinterface

// File: rtl/mem_region_ctrl_byte_ram.sv
// byte_ram: DEPTH x 32-bit RAM with per-byte write enables, synchronous
// write and synchronous read. Contents are not reset.
// Ports: clk, we, be[3:0], addr, wdata[31:0], re, rdata[31:0] (registered).
`timescale 1ns/1ps
module byte_ram #(
  parameter  int unsigned DEPTH = 1024,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic          re,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Byte-lane write and registered read share one port address
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_region_ctrl.sv
// mem_region_ctrl: data-memory controller for the MIPS core.
// Decodes byte addresses against the text/static/dynamic map, owns the
// static and dynamic RAMs and runs each access as a multi-cycle transaction.
// Ports: clk, rst_n (async active-low), bus (slave side of the load/store
// port), gp_init / sp_init (constant initial pointer values).
`timescale 1ns/1ps
module mem_region_ctrl
  import mem_map_pkg::*;
#(
  parameter logic [31:0] TEXT_BASE   = DEF_TEXT_BASE,
  parameter int unsigned TEXT_WORDS  = DEF_TEXT_WORDS,
  parameter logic [31:0] STATIC_BASE = DEF_STATIC_BASE,
  parameter logic [31:0] DYN_BASE    = DEF_DYN_BASE,
  parameter int unsigned DATA_WORDS  = DEF_DATA_WORDS,
  parameter int unsigned WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_region_ctrl_if.slave bus,
  output logic [31:0]     gp_init,
  output logic [31:0]     sp_init
);

  localparam int unsigned AW = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
  // Region bounds widened to 33 bits so a region ending at 2^32 never wraps
  localparam logic [32:0] TEXT_LO = {1'b0, TEXT_BASE};
  localparam logic [32:0] TEXT_HI = TEXT_LO + (33'(TEXT_WORDS) << 2);
  localparam logic [32:0] STAT_LO = {1'b0, STATIC_BASE};
  localparam logic [32:0] STAT_HI = STAT_LO + (33'(DATA_WORDS) << 2);
  localparam logic [32:0] DYN_LO  = {1'b0, DYN_BASE};
  localparam logic [32:0] DYN_HI  = DYN_LO + (33'(DATA_WORDS) << 2);
  localparam logic [3:0]  WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  if ((TEXT_LO < STAT_HI && STAT_LO < TEXT_HI) ||
      (TEXT_LO < DYN_HI  && DYN_LO  < TEXT_HI) ||
      (STAT_LO < DYN_HI  && DYN_LO  < STAT_HI) ||
      (WAIT_STATES > 15)) begin : g_cfg_err
    $error("mem_region_ctrl: overlapping memory map or WAIT_STATES > 15");
  end

  state_e        state_q, state_d;
  req_t          req_q, req_d;
  region_e       region_q, region_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_fault_q, rsp_fault_d;
  fault_e        rsp_code_q, rsp_code_d;

  region_e       region_c;
  fault_e        code_c;
  logic [AW-1:0] idx_c;
  logic [AW-1:0] ram_idx_c;
  logic          ram_re_c;
  logic          s_we_c, d_we_c;
  logic [31:0]   s_rdata, d_rdata;

  // Address decode of the incoming request; misaligned beats text beats unmapped
  always_comb begin
    region_c = REG_NONE;
    if ({1'b0, bus.req_addr} >= TEXT_LO && {1'b0, bus.req_addr} < TEXT_HI)
      region_c = REG_TEXT;
    else if ({1'b0, bus.req_addr} >= STAT_LO && {1'b0, bus.req_addr} < STAT_HI)
      region_c = REG_STATIC;
    else if ({1'b0, bus.req_addr} >= DYN_LO && {1'b0, bus.req_addr} < DYN_HI)
      region_c = REG_DYN;

    if (!legal_be(bus.req_be, bus.req_addr[1:0])) code_c = FC_MISALIGN;
    else if (region_c == REG_TEXT)                code_c = FC_TEXT;
    else if (region_c == REG_NONE)                code_c = FC_UNMAPPED;
    else                                          code_c = FC_NONE;

    if (region_c == REG_DYN) idx_c = AW'((bus.req_addr - DYN_BASE) >> 2);
    else                     idx_c = AW'((bus.req_addr - STATIC_BASE) >> 2);
  end

  // Next state and registered-output values
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    region_d    = region_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_fault_d = rsp_fault_q;
    rsp_code_d  = rsp_code_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          req_d    = '{we: bus.req_we, be: bus.req_be, wdata: bus.req_wdata};
          region_d = region_c;
          idx_d    = idx_c;
          if (code_c != FC_NONE) begin
            state_d     = RESP;
            rsp_rdata_d = '0;
            rsp_fault_d = 1'b1;
            rsp_code_d  = code_c;
          end else if (WAIT_STATES == 0) begin
            state_d = ACCESS;
          end else begin
            state_d = WAIT;
            cnt_d   = WS_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ACCESS: begin
        state_d     = RESP;
        rsp_fault_d = 1'b0;
        rsp_code_d  = FC_NONE;
        if (req_q.we) rsp_rdata_d = '0;
        else rsp_rdata_d = ((region_q == REG_DYN) ? d_rdata : s_rdata) & be_mask(req_q.be);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  // Read is launched on entry to ACCESS so data is ready while in ACCESS;
  // with zero wait states that entry happens straight from IDLE.
  assign ram_idx_c = (state_q == IDLE) ? idx_c : idx_q;
  assign ram_re_c  = (state_d == ACCESS);
  assign s_we_c    = (state_q == ACCESS) && req_q.we && (region_q == REG_STATIC);
  assign d_we_c    = (state_q == ACCESS) && req_q.we && (region_q == REG_DYN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_q       <= '0;
      region_q    <= REG_NONE;
      idx_q       <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_fault_q <= 1'b0;
      rsp_code_q  <= FC_NONE;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      region_q    <= region_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_fault_q <= rsp_fault_d;
      rsp_code_q  <= rsp_code_d;
    end
  end

  byte_ram #(.DEPTH(DATA_WORDS)) u_static_ram (
    .clk   (clk),
    .we    (s_we_c),
    .be    (req_q.be),
    .addr  (ram_idx_c),
    .wdata (req_q.wdata),
    .re    (ram_re_c),
    .rdata (s_rdata)
  );

  byte_ram #(.DEPTH(DATA_WORDS)) u_dyn_ram (
    .clk   (clk),
    .we    (d_we_c),
    .be    (req_q.be),
    .addr  (ram_idx_c),
    .wdata (req_q.wdata),
    .re    (ram_re_c),
    .rdata (d_rdata)
  );

  assign bus.req_ready      = req_ready_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_rdata      = rsp_rdata_q;
  assign bus.rsp_fault      = rsp_fault_q;
  assign bus.rsp_fault_code = rsp_code_q;
  assign gp_init            = DYN_BASE;
  assign sp_init            = DYN_BASE + (32'(DATA_WORDS) << 2);

endmodule
